beam_scan_controller: RTL and testbench

//  Sequences the angle->delay LUT for the 4-mic beamformer: sweeps the steering angle, waits for the delay

---
 rtl/beam_scan_controller_if.sv | 37 +++
 rtl/beam_scan_controller.sv | 141 ++++++++++++++
 tb/tb_beam_scan_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/beam_scan_controller_if.sv
// rtl/beam_scan_controller_if.sv - control/sample/result bundle between top-level control and the scan controller
interface beam_scan_controller_if #(
    parameter int SAMPLE_W      = 16,
    parameter int DWELL_SAMPLES = 64
);
    localparam int ACC_W = SAMPLE_W + $clog2(DWELL_SAMPLES + 1);

    logic                       start_in;
    logic                       abort_in;
    logic                       continuous_in;
    logic                       manual_en_in;
    logic [7:0]                 manual_angle_in;
    logic                       sample_valid_in;
    logic signed [SAMPLE_W-1:0] beam_sample_in;
    logic [7:0]                 angle_out;
    logic                       angle_update_out;
    logic                       busy_out;
    logic [ACC_W-1:0]           energy_out;
    logic                       energy_valid_out;
    logic [7:0]                 best_angle_out;
    logic [ACC_W-1:0]           best_energy_out;
    logic                       sweep_done_out;

    modport master (
        output start_in, abort_in, continuous_in, manual_en_in, manual_angle_in,
               sample_valid_in, beam_sample_in,
        input  angle_out, angle_update_out, busy_out, energy_out, energy_valid_out,
               best_angle_out, best_energy_out, sweep_done_out
    );

    modport slave (
        input  start_in, abort_in, continuous_in, manual_en_in, manual_angle_in,
               sample_valid_in, beam_sample_in,
        output angle_out, angle_update_out, busy_out, energy_out, energy_valid_out,
               best_angle_out, best_energy_out, sweep_done_out
    );
endinterface

// File: rtl/beam_scan_controller.sv
// rtl/beam_scan_controller.sv - angle sweep sequencer measuring beam energy per angle and tracking the peak
module beam_scan_controller #(
    parameter int SAMPLE_W       = 16,
    parameter int ANGLE_MIN      = 0,
    parameter int ANGLE_MAX      = 180,
    parameter int ANGLE_STEP     = 5,
    parameter int SETTLE_SAMPLES = 8,
    parameter int DWELL_SAMPLES  = 64
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    beam_scan_controller_if.slave   bus
);
    localparam int ACC_W   = SAMPLE_W + $clog2(DWELL_SAMPLES + 1);
    localparam int CNT_MAX = (SETTLE_SAMPLES > DWELL_SAMPLES) ? SETTLE_SAMPLES : DWELL_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, DWELL, COMPARE, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    run_energy;
    logic [7:0]          run_angle;
    logic                run_valid;
    logic [SAMPLE_W-1:0] mag;
    logic [7:0]          manual_clamped;
    logic [8:0]          next_angle;

    // Two's-complement negate of the most-negative value yields 2^(SAMPLE_W-1) when read unsigned.
    assign mag = bus.beam_sample_in[SAMPLE_W-1]
               ? ($unsigned(~bus.beam_sample_in) + SAMPLE_W'(1))
               : $unsigned(bus.beam_sample_in);
    assign manual_clamped = (bus.manual_angle_in > 8'd180) ? 8'd180 : bus.manual_angle_in;
    assign next_angle     = {1'b0, bus.angle_out} + 9'(ANGLE_STEP);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state                <= IDLE;
            cnt                  <= '0;
            acc                  <= '0;
            run_energy           <= '0;
            run_angle            <= '0;
            run_valid            <= 1'b0;
            bus.angle_out        <= 8'd90;
            bus.angle_update_out <= 1'b0;
            bus.busy_out         <= 1'b0;
            bus.energy_out       <= '0;
            bus.energy_valid_out <= 1'b0;
            bus.best_angle_out   <= '0;
            bus.best_energy_out  <= '0;
            bus.sweep_done_out   <= 1'b0;
        end else begin
            bus.angle_update_out <= 1'b0;
            bus.energy_valid_out <= 1'b0;
            bus.sweep_done_out   <= 1'b0;
            if (state != IDLE && bus.abort_in) begin
                state        <= IDLE;
                bus.busy_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start_in) begin
                            state                <= SETTLE;
                            cnt                  <= '0;
                            run_valid            <= 1'b0;
                            run_energy           <= '0;
                            run_angle            <= '0;
                            bus.angle_out        <= 8'(ANGLE_MIN);
                            bus.angle_update_out <= 1'b1;
                            bus.busy_out         <= 1'b1;
                        end else if (bus.manual_en_in && manual_clamped != bus.angle_out) begin
                            bus.angle_out        <= manual_clamped;
                            bus.angle_update_out <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (bus.sample_valid_in) begin
                            if (cnt == CNT_W'(SETTLE_SAMPLES - 1)) begin
                                cnt   <= '0;
                                acc   <= '0;
                                state <= DWELL;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    DWELL: begin
                        if (bus.sample_valid_in) begin
                            acc <= acc + ACC_W'(mag);
                            if (cnt == CNT_W'(DWELL_SAMPLES - 1)) begin
                                cnt   <= '0;
                                state <= COMPARE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    COMPARE: begin
                        bus.energy_out       <= acc;
                        bus.energy_valid_out <= 1'b1;
                        // Strict compare keeps the earliest angle on ties.
                        if (!run_valid || acc > run_energy) begin
                            run_valid  <= 1'b1;
                            run_energy <= acc;
                            run_angle  <= bus.angle_out;
                        end
                        if (next_angle <= 9'(ANGLE_MAX)) begin
                            bus.angle_out        <= next_angle[7:0];
                            bus.angle_update_out <= 1'b1;
                            state                <= SETTLE;
                        end else begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        bus.best_angle_out  <= run_angle;
                        bus.best_energy_out <= run_energy;
                        bus.sweep_done_out  <= 1'b1;
                        if (bus.continuous_in) begin
                            state                <= SETTLE;
                            cnt                  <= '0;
                            run_valid            <= 1'b0;
                            run_energy           <= '0;
                            run_angle            <= '0;
                            bus.angle_out        <= 8'(ANGLE_MIN);
                            bus.angle_update_out <= 1'b1;
                        end else begin
                            state        <= IDLE;
                            bus.busy_out <= 1'b0;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        bus.busy_out <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_beam_scan_controller.sv
// tb/tb_beam_scan_controller.sv - directed bench for beam_scan_controller across three parameter sets
module tb_beam_scan_controller;
    logic clk;
    logic rst_n;
    logic vld;
    int   vcnt;
    int   checks;
    int   errors;

    beam_scan_controller_if #(.SAMPLE_W(16), .DWELL_SAMPLES(8)) ifa ();
    beam_scan_controller_if #(.SAMPLE_W(8),  .DWELL_SAMPLES(8)) ifb ();
    beam_scan_controller_if #(.SAMPLE_W(16), .DWELL_SAMPLES(8)) ifc ();

    beam_scan_controller #(.SAMPLE_W(16), .ANGLE_MIN(0), .ANGLE_MAX(180), .ANGLE_STEP(10),
        .SETTLE_SAMPLES(4), .DWELL_SAMPLES(8)) dut_a (.clk_in(clk), .rst_n_in(rst_n), .bus(ifa));
    beam_scan_controller #(.SAMPLE_W(8), .ANGLE_MIN(0), .ANGLE_MAX(180), .ANGLE_STEP(10),
        .SETTLE_SAMPLES(4), .DWELL_SAMPLES(8)) dut_b (.clk_in(clk), .rst_n_in(rst_n), .bus(ifb));
    beam_scan_controller #(.SAMPLE_W(16), .ANGLE_MIN(0), .ANGLE_MAX(180), .ANGLE_STEP(50),
        .SETTLE_SAMPLES(4), .DWELL_SAMPLES(8)) dut_c (.clk_in(clk), .rst_n_in(rst_n), .bus(ifc));

    assign ifa.beam_sample_in  = (ifa.angle_out == 8'd60) ? 16'sd300 : 16'sd100;
    assign ifb.beam_sample_in  = 8'sh80;
    assign ifc.beam_sample_in  = 16'sd100;
    assign ifa.sample_valid_in = vld;
    assign ifb.sample_valid_in = vld;
    assign ifc.sample_valid_in = vld;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Qualifier high two cycles out of three so gaps in sample_valid are exercised.
    initial begin
        vld  = 1'b0;
        vcnt = 0;
        forever begin
            @(negedge clk);
            vcnt = (vcnt + 1) % 3;
            vld  = (vcnt != 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       men;
        logic [7:0] mang;
        logic       start;
        logic       abort;
        int         e_angle;
        int         e_upd;
        int         e_busy;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int  na, nb, nc, nce, ndone, cyc;
        bit  da, db, dc, found, bad;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ifa.start_in = 0; ifa.abort_in = 0; ifa.continuous_in = 0; ifa.manual_en_in = 0; ifa.manual_angle_in = 0;
        ifb.start_in = 0; ifb.abort_in = 0; ifb.continuous_in = 0; ifb.manual_en_in = 0; ifb.manual_angle_in = 0;
        ifc.start_in = 0; ifc.abort_in = 0; ifc.continuous_in = 0; ifc.manual_en_in = 0; ifc.manual_angle_in = 0;

        vecs[0] = '{1'b0, 8'd45,  1'b0, 1'b0, 90,  0, 0};
        vecs[1] = '{1'b1, 8'd45,  1'b0, 1'b0, 45,  1, 0};
        vecs[2] = '{1'b1, 8'd45,  1'b0, 1'b0, 45,  0, 0};
        vecs[3] = '{1'b1, 8'd200, 1'b0, 1'b0, 180, 1, 0};
        vecs[4] = '{1'b1, 8'd250, 1'b0, 1'b0, 180, 0, 0};
        vecs[5] = '{1'b1, 8'd180, 1'b0, 1'b0, 180, 0, 0};
        vecs[6] = '{1'b0, 8'd10,  1'b0, 1'b0, 180, 0, 0};
        vecs[7] = '{1'b1, 8'd10,  1'b0, 1'b0, 10,  1, 0};
        vecs[8] = '{1'b1, 8'd77,  1'b1, 1'b0, 0,   1, 1};
        vecs[9] = '{1'b0, 8'd77,  1'b0, 1'b1, 0,   0, 0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_angle", int'(ifa.angle_out), 90);
        chk("rst_busy", int'(ifa.busy_out), 0);
        chk("rst_update", int'(ifa.angle_update_out), 0);
        chk("rst_energy", int'(ifa.energy_out), 0);
        chk("rst_energy_valid", int'(ifa.energy_valid_out), 0);
        chk("rst_best_angle", int'(ifa.best_angle_out), 0);
        chk("rst_best_energy", int'(ifa.best_energy_out), 0);
        chk("rst_sweep_done", int'(ifa.sweep_done_out), 0);

        for (int i = 0; i < 10; i++) begin
            ifa.manual_en_in    = vecs[i].men;
            ifa.manual_angle_in = vecs[i].mang;
            ifa.start_in        = vecs[i].start;
            ifa.abort_in        = vecs[i].abort;
            @(negedge clk);
            chk($sformatf("vec%0d_angle", i), int'(ifa.angle_out), vecs[i].e_angle);
            chk($sformatf("vec%0d_update", i), int'(ifa.angle_update_out), vecs[i].e_upd);
            chk($sformatf("vec%0d_busy", i), int'(ifa.busy_out), vecs[i].e_busy);
        end
        ifa.manual_en_in = 0; ifa.start_in = 0; ifa.abort_in = 0;
        @(negedge clk);

        // Full sweeps on all three instances at once.
        ifa.start_in = 1; ifb.start_in = 1; ifc.start_in = 1;
        @(negedge clk);
        ifa.start_in = 0; ifb.start_in = 0; ifc.start_in = 0;
        na = 0; nb = 0; nc = 0; nce = 0; cyc = 0;
        da = 0; db = 0; dc = 0;
        while (cyc < 3000 && !(da && db && dc)) begin
            if (ifa.energy_valid_out) begin
                chk($sformatf("a_energy%0d", na), int'(ifa.energy_out), (na == 6) ? 2400 : 800);
                na++;
            end
            if (ifa.sweep_done_out) begin
                da = 1;
                chk("a_best_angle", int'(ifa.best_angle_out), 60);
                chk("a_best_energy", int'(ifa.best_energy_out), 2400);
                chk("a_busy_after_done", int'(ifa.busy_out), 0);
            end
            if (ifb.energy_valid_out) begin
                chk($sformatf("b_energy%0d", nb), int'(ifb.energy_out), 1024);
                nb++;
            end
            if (ifb.sweep_done_out) begin
                db = 1;
                chk("b_best_angle", int'(ifb.best_angle_out), 0);
                chk("b_best_energy", int'(ifb.best_energy_out), 1024);
            end
            if (ifc.angle_update_out) begin
                chk($sformatf("c_angle%0d", nc), int'(ifc.angle_out), nc * 50);
                nc++;
            end
            if (ifc.energy_valid_out) nce++;
            if (ifc.sweep_done_out) begin
                dc = 1;
                chk("c_hold_angle", int'(ifc.angle_out), 150);
            end
            @(negedge clk);
            cyc++;
        end
        chk("sweep_timeout", int'(da && db && dc), 1);
        chk("a_energy_count", na, 19);
        chk("b_energy_count", nb, 19);
        chk("c_update_count", nc, 4);
        chk("c_energy_count", nce, 4);

        // Abort while dwelling at 30 degrees.
        ifa.start_in = 1;
        @(negedge clk);
        ifa.start_in = 0;
        found = 0;
        cyc   = 0;
        while (cyc < 500 && !found) begin
            if (ifa.angle_update_out && ifa.angle_out == 8'd30) found = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("abort_reach30", int'(found), 1);
        repeat (9) @(negedge clk);
        ifa.abort_in = 1;
        @(negedge clk);
        ifa.abort_in = 0;
        chk("abort_busy", int'(ifa.busy_out), 0);
        chk("abort_angle", int'(ifa.angle_out), 30);
        chk("abort_energy_valid", int'(ifa.energy_valid_out), 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifa.sweep_done_out || ifa.energy_valid_out || ifa.busy_out) bad = 1;
        end
        chk("abort_quiet", int'(bad), 0);
        chk("abort_best_angle", int'(ifa.best_angle_out), 60);
        chk("abort_best_energy", int'(ifa.best_energy_out), 2400);
        chk("abort_angle_hold", int'(ifa.angle_out), 30);

        // Start while busy is ignored; continuous mode gives back-to-back sweeps.
        ifc.continuous_in = 1;
        ifc.start_in = 1;
        @(negedge clk);
        ifc.start_in = 0;
        ndone = 0;
        cyc   = 0;
        while (cyc < 2000 && ndone < 2) begin
            if (ifc.sweep_done_out) begin
                ndone++;
                if (ndone == 1) begin
                    chk("cont_busy", int'(ifc.busy_out), 1);
                    chk("cont_restart_update", int'(ifc.angle_update_out), 1);
                    chk("cont_restart_angle", int'(ifc.angle_out), 0);
                    ifc.continuous_in = 0;
                end else begin
                    chk("cont_end_busy", int'(ifc.busy_out), 0);
                    chk("cont_best_angle", int'(ifc.best_angle_out), 0);
                    chk("cont_best_energy", int'(ifc.best_energy_out), 800);
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk("cont_done_count", ndone, 2);

        // Asynchronous reset in the middle of SETTLE.
        ifa.start_in = 1;
        @(negedge clk);
        ifa.start_in = 0;
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", int'(ifa.busy_out), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_angle", int'(ifa.angle_out), 90);
        chk("async_rst_busy", int'(ifa.busy_out), 0);
        chk("async_rst_best_angle", int'(ifa.best_angle_out), 0);
        chk("async_rst_best_energy", int'(ifa.best_energy_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", int'(ifa.busy_out), 0);
        chk("post_rst_angle", int'(ifa.angle_out), 90);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
